// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/redirect controller: per-register stall/flush and PC redirect.
// Optional perf counters enabled by defining PIPE_PERF_CNT_EN.
module pipeline_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stallreq,
    input  logic        id_stallreq,
    input  logic        ex_stallreq,
    input  logic        mem_stallreq,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    input  logic        if_busy,
    output logic [4:0]  stall,
    output logic [4:0]  flush,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN,
        WAIT_IF,
        REDIRECT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic        redir_valid_q, redir_valid_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [4:0]  stall_c, flush_c;

    // Next-state, latched target and per-register stall/flush decode
    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        stall_c = 5'b00000;
        flush_c = 5'b00000;
        unique case (state_q)
            RUN: begin
                if (exc_req) begin
                    stall_c = 5'b00001;
                    flush_c = 5'b11110;
                    epc_d   = exc_pc;
                    state_d = if_busy ? WAIT_IF : REDIRECT;
                end else if (mem_stallreq) begin
                    stall_c = 5'b01111;
                    flush_c = 5'b10000;
                end else if (ex_stallreq) begin
                    stall_c = 5'b00111;
                    flush_c = 5'b01000;
                end else if (id_stallreq) begin
                    stall_c = 5'b00011;
                    flush_c = 5'b00100;
                end else if (if_stallreq) begin
                    stall_c = 5'b00001;
                    flush_c = 5'b00010;
                end
            end
            WAIT_IF: begin
                stall_c = 5'b00001;
                flush_c = 5'b11110;
                if (!if_busy) state_d = REDIRECT;
            end
            REDIRECT: begin
                flush_c = 5'b11110;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        // Strobe is registered so it lines up with the REDIRECT cycle
        redir_valid_d = (state_d == REDIRECT);
        redir_pc_d    = redir_valid_d ? epc_d : redir_pc_q;
    end

    // State and redirect registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            epc_q         <= 32'd0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            epc_q         <= epc_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    // Controls are forced quiet while reset is held
    assign stall       = rst ? 5'b00000 : stall_c;
    assign flush       = rst ? 5'b00000 : flush_c;
    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Counter increments; both wrap naturally at 32 bits
    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, |stall_c};
        flush_cnt_d = flush_cnt_q + {31'd0, redir_valid_q};
    end

    // Performance counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule
